harmonic_scheduler: RTL and testbench

Sequences the per-harmonic sample-position datapath once per output sample. It steps the harmonic index, handshakes each harmonic sample in, scales and accumulates it, and ends the frame at the harmonic count or when the datapath flags the next harmonic as above audible range. It then presents one saturated 16-bit sample to the DAC path and waits for the next sample-rate tick before restarting at the fundamental.

---
 rtl/harmonic_scheduler_if.sv | 42 ++++
 rtl/harmonic_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_harmonic_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/harmonic_scheduler_if.sv
// harmonic_scheduler_if
//   Per-harmonic datapath link between the harmonic scheduler (master) and
//   the sample-position datapath / level table (slave).
//
//   o_Harmonic       scheduler -> datapath  current harmonic index
//   o_Next_Sample    scheduler -> datapath  one-cycle "consumed, advance" pulse
//   i_Sample_Ready   datapath -> scheduler  sample position loaded for o_Harmonic
//   i_Sample_Value   datapath -> scheduler  signed sine sample
//   i_Freq_Too_High  datapath -> scheduler  next harmonic is above audible range
//   i_Scale          datapath -> scheduler  unsigned amplitude for o_Harmonic
//
// Handshake: i_Sample_Ready acts as "valid" for the sample belonging to
// o_Harmonic; the scheduler accepts it when it is waiting for a sample, and
// o_Next_Sample acts as the matching "ready/consume" pulse that tells the
// datapath to drop ready and load the next position. o_Harmonic never changes
// while o_Next_Sample is high.
interface harmonic_scheduler_if;
  logic        [7:0]  o_Harmonic;
  logic               o_Next_Sample;
  logic               i_Sample_Ready;
  logic signed [15:0] i_Sample_Value;
  logic               i_Freq_Too_High;
  logic        [7:0]  i_Scale;

  modport master (
    output o_Harmonic,
    output o_Next_Sample,
    input  i_Sample_Ready,
    input  i_Sample_Value,
    input  i_Freq_Too_High,
    input  i_Scale
  );

  modport slave (
    input  o_Harmonic,
    input  o_Next_Sample,
    output i_Sample_Ready,
    output i_Sample_Value,
    output i_Freq_Too_High,
    output i_Scale
  );
endinterface

// File: rtl/harmonic_scheduler.sv
// harmonic_scheduler
//   Once per output sample, walks the harmonic index from the fundamental,
//   accepts each harmonic's sine sample from the datapath, scales and
//   accumulates it, and ends the frame at the harmonic count or when the
//   datapath flags the next harmonic as inaudible. The accumulator is then
//   shifted, saturated to 16 bits and presented to the DAC path; the
//   scheduler then waits for the next sample-rate tick.
//
// Ports:
//   i_Clock, i_Reset     clock, synchronous active-high reset
//   i_Sample_Tick        one-cycle strobe at the output sample rate
//   i_Harmonic_Count     requested harmonics per frame (sampled at frame start)
//   dp                   datapath link (see harmonic_scheduler_if)
//   o_Sample_Out         signed saturated mixed sample
//   o_Sample_Valid       one-cycle strobe when o_Sample_Out updates
//   o_Overrun            one-cycle pulse when a sample tick is dropped
//   o_State_Dbg          current FSM state encoding
module harmonic_scheduler #(
  parameter int NUM_HARMONICS = 200,
  parameter int OUT_SHIFT     = 12
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  input  logic                i_Sample_Tick,
  input  logic        [7:0]   i_Harmonic_Count,
  harmonic_scheduler_if.master dp,
  output logic signed [15:0]  o_Sample_Out,
  output logic                o_Sample_Valid,
  output logic                o_Overrun,
  output logic        [2:0]   o_State_Dbg
);

  typedef enum logic [2:0] {
    S_WAIT_READY = 3'd0,
    S_SETTLE     = 3'd1,
    S_MAC        = 3'd2,
    S_DECIDE     = 3'd3,
    S_NEXT       = 3'd4,
    S_OUTPUT     = 3'd5,
    S_IDLE       = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic        [7:0]  harm_q, harm_d;
  logic signed [31:0] acc_q, acc_d;
  logic        [7:0]  count_q, count_d;
  logic               pending_q, pending_d;
  logic               ns_pulse_q;
  logic               ns_pulse;
  logic signed [15:0] out_q, out_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  // 0 requests are treated as a single-harmonic frame; large requests are
  // limited to what the design is built for.
  function automatic logic [7:0] clamp_count(input logic [7:0] c);
    if (c == 8'd0)                   return 8'd1;
    else if (int'(c) > NUM_HARMONICS) return 8'(NUM_HARMONICS);
    else                             return c;
  endfunction

  // Sample times unsigned scale: the scale is zero-extended so 128..255 stay
  // positive.
  logic signed [24:0] val_ext;
  logic signed [24:0] scale_ext;
  logic signed [24:0] prod;
  assign val_ext   = 25'(dp.i_Sample_Value);
  assign scale_ext = $signed({17'd0, dp.i_Scale});
  assign prod      = val_ext * scale_ext;

  logic signed [31:0] shifted;
  logic signed [15:0] sat;
  assign shifted = acc_q >>> OUT_SHIFT;
  always_comb begin
    if (shifted > 32'sd32767)       sat = 16'sh7FFF;
    else if (shifted < -32'sd32768) sat = 16'sh8000;
    else                            sat = shifted[15:0];
  end

  logic tick_avail;
  logic last_harm;
  assign tick_avail = i_Sample_Tick || pending_q;
  assign last_harm  = (harm_q == (count_q - 8'd1));

  always_comb begin
    state_d   = state_q;
    harm_d    = harm_q;
    acc_d     = acc_q;
    count_d   = count_q;
    pending_d = pending_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    ovr_d     = 1'b0;
    ns_pulse  = 1'b0;

    case (state_q)
      S_WAIT_READY: begin
        // The datapath may still show the previous harmonic's ready in the
        // cycle right after a consume pulse, so that cycle is ignored.
        if (dp.i_Sample_Ready && !ns_pulse_q) state_d = S_SETTLE;
      end
      S_SETTLE: state_d = S_MAC;
      S_MAC: begin
        acc_d   = acc_q + 32'(prod);
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (dp.i_Freq_Too_High || last_harm) begin
          // Load the result here so data and strobe both appear in the
          // cycle right after the final decision.
          out_d   = sat;
          valid_d = 1'b1;
          state_d = S_OUTPUT;
        end else begin
          harm_d  = harm_q + 8'd1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        ns_pulse = 1'b1;
        state_d  = S_WAIT_READY;
      end
      S_OUTPUT: begin
        acc_d   = 32'sd0;
        harm_d  = 8'd0;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (tick_avail) begin
          count_d  = clamp_count(i_Harmonic_Count);
          ns_pulse = 1'b1;
          state_d  = S_WAIT_READY;
        end
      end
      default: state_d = S_WAIT_READY;
    endcase

    // Only one tick can be held. When IDLE consumes a pending tick while a
    // fresh one arrives, the fresh one takes its place.
    if (state_q == S_IDLE && tick_avail) begin
      pending_d = pending_q && i_Sample_Tick;
    end else if (i_Sample_Tick) begin
      if (pending_q) ovr_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  // Reset lands in WAIT_READY: the datapath self-starts harmonic 0.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_WAIT_READY;
      harm_q     <= 8'd0;
      acc_q      <= 32'sd0;
      count_q    <= clamp_count(i_Harmonic_Count);
      pending_q  <= 1'b0;
      ns_pulse_q <= 1'b0;
      out_q      <= 16'sd0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      harm_q     <= harm_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      ns_pulse_q <= ns_pulse;
      out_q      <= out_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dp.o_Harmonic    = harm_q;
  assign dp.o_Next_Sample = ns_pulse;
  assign o_Sample_Out     = out_q;
  assign o_Sample_Valid   = valid_q;
  assign o_Overrun        = ovr_q;
  assign o_State_Dbg      = state_q;

endmodule

// File: tb/tb_harmonic_scheduler.sv
// tb_harmonic_scheduler
//   Directed bench for harmonic_scheduler (OUT_SHIFT=4, NUM_HARMONICS=200).
//   A reactive datapath model answers each o_Next_Sample with a ready after a
//   fixed latency and supplies per-harmonic values, scale and the
//   too-high flag from bench-side tables.
module tb_harmonic_scheduler;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic [7:0] hcount;
  logic signed [15:0] sample_out;
  logic sample_valid;
  logic overrun;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  harmonic_scheduler_if dp_if();

  harmonic_scheduler #(.NUM_HARMONICS(200), .OUT_SHIFT(4)) dut (
    .i_Clock          (clk),
    .i_Reset          (rst),
    .i_Sample_Tick    (tick),
    .i_Harmonic_Count (hcount),
    .dp               (dp_if),
    .o_Sample_Out     (sample_out),
    .o_Sample_Valid   (sample_valid),
    .o_Overrun        (overrun),
    .o_State_Dbg      (state_dbg)
  );

  // ---------------- datapath model + monitor ----------------
  int vals[256];
  int scale_v;
  int stop_h;   // harmonic index from which the too-high flag is set (256 = never)
  int lat;
  int cyc = 0;
  int n_start = 0, n_mid = 0, n_valid = 0, n_ovr = 0, seq_bad = 0;
  int last_h = 0, valid_cyc = 0, start_gap = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      dp_if.i_Sample_Ready = 1'b0;
      lat = LAT;
    end else begin
      if (dp_if.o_Next_Sample) begin
        dp_if.i_Sample_Ready = 1'b0;
        lat = LAT;
        if (dp_if.o_Harmonic == 8'd0) begin
          n_start++;
          last_h = 0;
          start_gap = cyc - valid_cyc;
        end else begin
          n_mid++;
          if (int'(dp_if.o_Harmonic) != last_h + 1) seq_bad++;
          last_h = int'(dp_if.o_Harmonic);
        end
      end else if (lat > 0) begin
        lat--;
      end else begin
        dp_if.i_Sample_Ready = 1'b1;
      end
      if (sample_valid) begin
        n_valid++;
        valid_cyc = cyc;
        got_q.push_back(sample_out);
      end
      if (overrun) n_ovr++;
    end
    dp_if.i_Sample_Value  = 16'(vals[dp_if.o_Harmonic]);
    dp_if.i_Scale         = 8'(scale_v);
    dp_if.i_Freq_Too_High = (int'(dp_if.o_Harmonic) >= stop_h);
  end

  // ---------------- scoreboard helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name);
    logic signed [15:0] g, e;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no sample (%0d captured, %0d expected)", name, got_q.size(), exp_q.size());
    end else begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check(name, int'(g), int'(e));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int target, input int budget, input string name);
    int k = 0;
    while (n_valid < target && k < budget) begin
      cycles(1);
      k++;
    end
    if (n_valid < target) check({name, " timeout"}, n_valid, target);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
  endtask

  task automatic set_pattern(input int base, input int step, input int scale, input int stop);
    for (int h = 0; h < 256; h++) vals[h] = base + step * h;
    scale_v = scale;
    stop_h  = stop;
  endtask

  task automatic check_reset(input string name);
    check({name, " harmonic"}, int'(dp_if.o_Harmonic), 0);
    check({name, " next"}, int'(dp_if.o_Next_Sample), 0);
    check({name, " out"}, int'(sample_out), 0);
    check({name, " valid"}, int'(sample_valid), 0);
    check({name, " overrun"}, int'(overrun), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int count;
    int scale;
    int base;
    int step;
    int stop;
    int exp_out;
    int exp_h;
  } vec_t;

  vec_t vt[8];

  initial begin
    int s0, m0, q0, o0, v0, k;

    // value = base + step*h; result = sat((sum value*scale) >>> 4)
    vt[0] = '{3,   16,  1000,   1000, 256, 6000,   3};   // 96000>>4
    vt[1] = '{10,  16,  100,    100,  4,   1500,   5};   // stop at h4: 24000>>4
    vt[2] = '{200, 255, 32767,  0,    256, 32767,  200}; // positive saturation
    vt[3] = '{200, 255, -32767, 0,    256, -32768, 200}; // negative saturation
    vt[4] = '{0,   16,  1000,   0,    256, 1000,   1};   // count 0 -> 1
    vt[5] = '{255, 1,   16,     0,    256, 200,    200}; // clamp 255 -> 200
    vt[6] = '{2,   1,   -1,     0,    256, -1,     2};   // -2 >>> 4 = -1
    vt[7] = '{2,   200, 10,     0,    256, 250,    2};   // scale above 127 is unsigned

    rst = 1'b1;
    tick = 1'b0;
    hcount = 8'd3;
    set_pattern(1000, 1000, 16, 256);
    cycles(3);
    check_reset("reset");

    // Frame 0 runs without a tick, using the count sampled during reset.
    exp_q.push_back(16'(6000));
    rst = 1'b0;
    wait_valid(1, 500, "frame0");
    cycles(10);
    check_out("frame0 out");
    check("frame0 idle harmonic", int'(dp_if.o_Harmonic), 0);
    check("frame0 no start pulse", n_start, 0);

    for (int i = 0; i < 8; i++) begin
      hcount = 8'(vt[i].count);
      set_pattern(vt[i].base, vt[i].step, vt[i].scale, vt[i].stop);
      s0 = n_start; m0 = n_mid; q0 = seq_bad; o0 = n_ovr; v0 = n_valid;
      exp_q.push_back(16'(vt[i].exp_out));
      pulse_tick();
      wait_valid(v0 + 1, 5000, $sformatf("vec%0d", i));
      cycles(10);
      check_out($sformatf("vec%0d out", i));
      check($sformatf("vec%0d mid pulses", i), n_mid - m0, vt[i].exp_h - 1);
      check($sformatf("vec%0d start pulses", i), n_start - s0, 1);
      check($sformatf("vec%0d last harmonic", i), last_h, vt[i].exp_h - 1);
      check($sformatf("vec%0d harmonic order", i), seq_bad - q0, 0);
      check($sformatf("vec%0d idle harmonic", i), int'(dp_if.o_Harmonic), 0);
      check($sformatf("vec%0d valid strobes", i), n_valid - v0, 1);
      check($sformatf("vec%0d overruns", i), n_ovr - o0, 0);
    end

    // Three ticks during one busy frame: one pending, one dropped.
    hcount = 8'd10;
    set_pattern(100, 100, 16, 256);
    s0 = n_start; o0 = n_ovr; v0 = n_valid;
    exp_q.push_back(16'(5500));
    exp_q.push_back(16'(5500));
    pulse_tick();
    cycles(5);
    pulse_tick();
    cycles(5);
    pulse_tick();
    wait_valid(v0 + 2, 3000, "overrun");
    cycles(10);
    check_out("overrun frame1 out");
    check_out("overrun frame2 out");
    check("overrun pulses", n_ovr - o0, 1);
    check("overrun start pulses", n_start - s0, 2);
    check("pending start gap", start_gap, 1);
    check("overrun valid strobes", n_valid - v0, 2);

    // Reset in the middle of harmonic 5.
    hcount = 8'd10;
    set_pattern(100, 100, 16, 256);
    pulse_tick();
    k = 0;
    while (dp_if.o_Harmonic != 8'd5 && k < 2000) begin
      cycles(1);
      k++;
    end
    check("reach harmonic 5", int'(dp_if.o_Harmonic), 5);
    rst = 1'b1;
    hcount = 8'd3;
    set_pattern(1000, 1000, 16, 256);
    v0 = n_valid;
    cycles(1);
    check_reset("midframe reset");
    rst = 1'b0;
    exp_q.push_back(16'(6000));
    wait_valid(v0 + 1, 500, "post-reset frame");
    cycles(10);
    check_out("post-reset out");
    check("post-reset valid strobes", n_valid - v0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete (%0d tests run, %0d failed)", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
